// File: rtl/pad_event_scheduler.sv
// Pad event scheduler: latches debounced pad ticks into per-pad pending bits,
// grants one pending pad per cycle round-robin into a command FIFO, and
// accounts for ticks lost because their pad was already pending.
module pad_event_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                          pclk,
    input  logic                          rst,
    input  logic                          pad_Sd,
    input  logic                          pad_Rd,
    input  logic                          pad_Ld,
    input  logic                          pad_Dd,
    input  logic                          cmd_ready,
    input  logic                          clr_ovf,
    output logic                          cmd_valid,
    output logic [1:0]                    cmd_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [CNT_W-1:0]              drop_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CNT_W + 3;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : gen_bad_depth
        $error("pad_event_scheduler: FIFO_DEPTH must be a power of two in 2..16");
    end

    logic [3:0]       tick;
    logic [3:0]       pending_q, pending_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [1:0]       mem_q [FIFO_DEPTH];

    logic             room;
    logic             grant_vld;
    logic [1:0]       grant_code;
    logic [1:0]       srch_idx;
    logic [3:0]       grant_oh;
    logic [3:0]       drop_vec;
    logic [2:0]       n_drop;
    logic [SW-1:0]    drop_sum;
    logic             push;
    logic             pop;

    assign tick = {pad_Dd, pad_Ld, pad_Rd, pad_Sd};

    // Room is judged on the registered count only; a same-cycle pop never frees a slot.
    assign room = (count_q < CW'(FIFO_DEPTH));

    // Round-robin search over pending pads starting at rr_ptr.
    always_comb begin
        grant_vld  = 1'b0;
        grant_code = 2'd0;
        srch_idx   = 2'd0;
        if (room) begin
            for (int i = 0; i < 4; i++) begin
                srch_idx = rr_ptr_q + 2'(i);
                if (!grant_vld && pending_q[srch_idx]) begin
                    grant_vld  = 1'b1;
                    grant_code = srch_idx;
                end
            end
        end
        grant_oh = grant_vld ? (4'b0001 << grant_code) : 4'b0000;
    end

    // Pending update, drop detection and FIFO/counter next state.
    always_comb begin
        // A tick on the granted pad re-arms it as a fresh event instead of dropping.
        drop_vec  = tick & pending_q & ~grant_oh;
        pending_d = (pending_q & ~grant_oh) | tick;
        rr_ptr_d  = grant_vld ? (grant_code + 2'd1) : rr_ptr_q;

        n_drop   = 3'(drop_vec[0]) + 3'(drop_vec[1]) + 3'(drop_vec[2]) + 3'(drop_vec[3]);
        drop_sum = SW'(drop_cnt_q) + SW'(n_drop);

        if (clr_ovf) begin
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            drop_cnt_d = (drop_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                         : drop_sum[CNT_W-1:0];
            overflow_d = overflow_q | (|drop_vec);
        end

        push     = grant_vld;
        pop      = (count_q != '0) && cmd_ready;
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Control state with asynchronous reset.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // FIFO storage; contents are masked at the output while empty, so no reset needed.
    always_ff @(posedge pclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= grant_code;
        end
    end

    assign cmd_valid  = (count_q != '0);
    assign cmd_code   = cmd_valid ? mem_q[rd_ptr_q] : 2'd0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pad_event_scheduler.sv
// Scoreboard bench for pad_event_scheduler: expected codes are queued when
// ticks are issued and a negedge monitor checks every accepted command.
module tb_pad_event_scheduler;

    logic       pclk;
    logic       rst;
    logic [3:0] ticks;
    logic       cmd_ready;
    logic       clr_ovf;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] drop_cnt;

    int n_tests;
    int n_fail;
    int exp_q[$];

    pad_event_scheduler #(
        .FIFO_DEPTH(4),
        .CNT_W     (8)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .pad_Sd    (ticks[0]),
        .pad_Rd    (ticks[1]),
        .pad_Ld    (ticks[2]),
        .pad_Dd    (ticks[3]),
        .cmd_ready (cmd_ready),
        .clr_ovf   (clr_ovf),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Monitor: every accepted command must match the head of the scoreboard.
    always @(negedge pclk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got code %0d, expected no command", cmd_code);
            end else begin
                chk("sb_code", int'(cmd_code), exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        ticks     = 4'b0000;
        cmd_ready = 1'b0;
        clr_ovf   = 1'b0;

        // Reset values
        #3;
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_code", int'(cmd_code), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single tick on L: visible one edge after it is sampled
        ticks = 4'b0100;
        step();
        ticks = 4'b0000;
        chk("lat_not_yet", int'(cmd_valid), 0);
        step();
        chk("single_valid", int'(cmd_valid), 1);
        chk("single_code", int'(cmd_code), 2);
        chk("single_count", int'(fifo_count), 1);
        exp_q.push_back(2);
        cmd_ready = 1'b1;
        step();
        chk("single_drained", int'(fifo_count), 0);

        // All four pads at once after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) exp_q.push_back(c);
        ticks = 4'b1111;
        step();
        ticks = 4'b0000;
        repeat (6) step();
        chk("simul_drop", int'(drop_cnt), 0);
        chk("simul_ovf", int'(overflow), 0);
        chk("simul_rr", int'(dut.rr_ptr_q), 0);
        chk("simul_count", int'(fifo_count), 0);

        // Fairness: S and D re-ticked every cycle alternate grants
        for (int c = 0; c < 7; c++) exp_q.push_back((c % 2 == 0) ? 0 : 3);
        ticks = 4'b1001;
        repeat (6) step();
        ticks = 4'b0000;
        repeat (6) step();
        chk("fair_drop", int'(drop_cnt), 5);
        chk("fair_ovf", int'(overflow), 1);
        chk("fair_count", int'(fifo_count), 0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_drop", int'(drop_cnt), 0);
        chk("clr_ovf", int'(overflow), 0);

        // Full FIFO: six ticks, last two stay pending, re-tick of S is dropped
        cmd_ready = 1'b0;
        for (int c = 0; c < 6; c++) exp_q.push_back(c % 4);
        for (int c = 0; c < 6; c++) begin
            ticks = 4'b0001 << (c % 4);
            step();
        end
        ticks = 4'b0000;
        step();
        step();
        chk("full_count", int'(fifo_count), 4);
        chk("full_pending", int'(dut.pending_q), 3);
        ticks = 4'b0001;
        step();
        ticks = 4'b0000;
        chk("full_drop", int'(drop_cnt), 1);
        chk("full_ovf", int'(overflow), 1);
        chk("full_pending2", int'(dut.pending_q), 3);
        cmd_ready = 1'b1;
        repeat (10) step();
        chk("full_drained", int'(fifo_count), 0);

        // Saturation: 16 drops after six edges, then saturate, then clear
        cmd_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ticks = 4'b1111;
        repeat (6) step();
        chk("sat_drop16", int'(drop_cnt), 16);
        chk("sat_count", int'(fifo_count), 4);
        repeat (74) step();
        chk("sat_drop255", int'(drop_cnt), 255);
        chk("sat_ovf", int'(overflow), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        ticks = 4'b0000;
        chk("sat_clr_drop", int'(drop_cnt), 0);
        chk("sat_clr_ovf", int'(overflow), 0);

        // Reset mid-stream with three queued commands and two pending pads
        rst = 1'b1;
        step();
        rst = 1'b0;
        ticks = 4'b1111;
        step();
        ticks = 4'b0000;
        step();
        step();
        ticks = 4'b0001;
        step();
        ticks = 4'b0000;
        chk("mid_count", int'(fifo_count), 3);
        chk("mid_pending", int'(dut.pending_q), 9);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(cmd_valid), 0);
        chk("mid_rst_code", int'(cmd_code), 0);
        chk("mid_rst_count", int'(fifo_count), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        chk("mid_rst_drop", int'(drop_cnt), 0);
        chk("mid_rst_pending", int'(dut.pending_q), 0);
        step();
        rst = 1'b0;
        cmd_ready = 1'b1;
        repeat (5) step();
        chk("post_rst_idle", int'(cmd_valid), 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
